load_align_unit: RTL and testbench

Read-side companion of the data segment: accepts a RISC-V load request (byte address plus funct3 width/sign code), drives the synchronous data-memory read port and returns the extended 32-bit load result. Stores are shifted into the RAM by the data segment. This block performs the inverse operation: it reads one or two words and shifts, merges and sign- or zero-extends them. Loads that span a word boundary (LW with addr[1:0]≠0, LH with addr[1:0]=3) are serviced with two back-to-back word reads. The block sits between the core's memory stage and port A of the data RAM.

---
 rtl/load_align_unit.sv | 152 +++++++++++++++
 tb/tb_load_align_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: turns a byte-addressed RISC-V load into one or two word
// reads on a synchronous RAM port and returns the shifted, extended result.
module load_align_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        CAP0 = 3'd2,
        CAP1 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  off;
    logic [2:0]  ltype;
    logic [29:0] w;
    logic [31:0] lo;
    logic        split;

    // Only word loads off alignment and halfword loads in the top byte lane cross a word.
    function automatic logic is_split(input logic [2:0] t, input logic [1:0] o);
        case (t)
            3'b010:         is_split = (o != 2'd0);
            3'b001, 3'b101: is_split = (o == 2'd3);
            default:        is_split = 1'b0;
        endcase
    endfunction

    // Returns {err, data}: shift the two-word window down by the byte offset, then extend.
    function automatic logic [32:0] align(input logic [2:0] t, input logic [1:0] o,
                                          input logic [31:0] h, input logic [31:0] l);
        logic [31:0] v;
        v = 32'({h, l} >> {o, 3'b000});
        case (t)
            3'b000:  align = {1'b0, {24{v[7]}}, v[7:0]};
            3'b001:  align = {1'b0, {16{v[15]}}, v[15:0]};
            3'b010:  align = {1'b0, v};
            3'b100:  align = {1'b0, 24'd0, v[7:0]};
            3'b101:  align = {1'b0, 16'd0, v[15:0]};
            default: align = {1'b1, 32'd0};
        endcase
    endfunction

    assign split = is_split(ltype, off);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = RD0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD0: state_nxt = CAP0;
            CAP0: begin
                if (split) begin
                    state_nxt = CAP1;
                end else begin
                    state_nxt = DONE;
                end
            end
            CAP1:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath and outputs. The second word address is issued while
    // the first read is in flight so the RAM sees two back-to-back reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= 30'd0;
            off        <= 2'd0;
            ltype      <= 3'd0;
            w          <= 30'd0;
            lo         <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off       <= req_addr[1:0];
                        ltype     <= req_type;
                        w         <= req_addr[31:2];
                        mem_addr  <= req_addr[31:2];
                        mem_en    <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                RD0: begin
                    if (split) begin
                        mem_addr <= w + 30'd1;
                    end else begin
                        mem_en <= 1'b0;
                    end
                end
                CAP0: begin
                    lo     <= mem_rd;
                    mem_en <= 1'b0;
                    if (!split) begin
                        {resp_err, resp_data} <= align(ltype, off, 32'd0, mem_rd);
                        resp_valid            <= 1'b1;
                    end
                end
                CAP1: begin
                    {resp_err, resp_data} <= align(ltype, off, mem_rd, lo);
                    resp_valid            <= 1'b1;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: byte-level reference model of RISC-V loads over a
// sparse word memory, per-cycle output comparison, directed and random loads.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rd;

    load_align_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] rdw(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic int ref_size(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // {err, data} of a load, assembled byte by byte from little-endian memory.
    function automatic logic [32:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        int          size;
        logic [31:0] val;
        logic [31:0] ba;
        logic [31:0] wd;
        size = ref_size(t);
        if (size == 0) return {1'b1, 32'h0};
        val = 32'h0;
        for (int i = 0; i < size; i++) begin
            ba  = a + 32'(i);
            wd  = rdw(ba[31:2]);
            val = val | (((wd >> (8 * ba[1:0])) & 32'hFF) << (8 * i));
        end
        if (t[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | (32'hFFFFFFFF << (8 * size));
        return {1'b0, val};
    endfunction

    // Latency from first address cycle to response: one extra when the bytes cross a word.
    function automatic int ref_lat(input logic [31:0] a, input logic [2:0] t);
        return ((int'(a[1:0]) + ref_size(t)) > 4) ? 3 : 2;
    endfunction

    // Synchronous RAM; garbage when not enabled so stale data cannot pass.
    always @(posedge clk) begin
        if (mem_en) mem_rd <= rdw(mem_addr);
        else        mem_rd <= $urandom;
    end

    int          cyc = 0;
    logic        has_load = 1'b0;
    int          acc = 0;
    int          lat = 0;
    logic [29:0] exp_w;
    logic [31:0] exp_data;
    logic        exp_err;

    // Model: accepts a request whenever the previous load has fully retired.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            has_load <= 1'b0;
        end else if (req_valid && (!has_load || cyc >= acc + lat + 1)) begin
            has_load              <= 1'b1;
            acc                   <= cyc + 1;
            lat                   <= ref_lat(req_addr, req_type);
            exp_w                 <= req_addr[31:2];
            {exp_err, exp_data}   <= ref_load(req_addr, req_type);
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = 32'h0;
    logic        last_err = 1'b0;
    logic        lit_valid = 1'b0;
    int          lit_acc = 0;
    logic [31:0] lit_data;
    logic        lit_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
        end
    endtask

    // Compare process: every output, every cycle.
    always @(negedge clk) begin : mon
        int k;
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 32'd1);
            chk("rst_valid", 32'(resp_valid), 32'd0);
            chk("rst_data", resp_data, 32'd0);
            chk("rst_err", 32'(resp_err), 32'd0);
            chk("rst_en", 32'(mem_en), 32'd0);
            chk("rst_addr", {2'b0, mem_addr}, 32'd0);
            last_data = 32'h0;
            last_err  = 1'b0;
        end else if (has_load && cyc >= acc && cyc <= acc + lat) begin
            k = cyc - acc;
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("mem_en", 32'(mem_en), 32'((k == 0) || (k == 1 && lat == 3)));
            if (k == 0) chk("mem_addr0", {2'b0, mem_addr}, {2'b0, exp_w});
            if (k == 1 && lat == 3) chk("mem_addr1", {2'b0, mem_addr}, {2'b0, exp_w + 30'd1});
            chk("resp_valid", 32'(resp_valid), 32'(k == lat));
            if (k == lat) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                if (lit_valid && lit_acc == acc) begin
                    chk("lit_data", resp_data, lit_data);
                    chk("lit_err", 32'(resp_err), 32'(lit_err));
                end
                last_data = exp_data;
                last_err  = exp_err;
            end else begin
                chk("hold_data", resp_data, last_data);
                chk("hold_err", 32'(resp_err), 32'(last_err));
            end
        end else begin
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_en", 32'(mem_en), 32'd0);
            chk("idle_valid", 32'(resp_valid), 32'd0);
            chk("idle_data", resp_data, last_data);
            chk("idle_err", 32'(resp_err), 32'(last_err));
        end
    end

    // Raise a request at the next falling edge and hold it until the model accepts.
    task automatic issue(input logic [31:0] a, input logic [2:0] t);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_type  = t;
        n = 0;
        while (!(has_load && acc == cyc) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            $display("FAIL accept_timeout: addr %h type %b not accepted", a, t);
            $fatal(1);
        end
        req_valid = 1'b0;
    endtask

    // Pin the current load's response to a hand-computed value and wait for it.
    task automatic expect_lit(input logic [31:0] d, input logic e);
        lit_data  = d;
        lit_err   = e;
        lit_acc   = acc;
        lit_valid = 1'b1;
        while (cyc <= acc + lat) @(negedge clk);
        lit_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d, input logic e);
        issue(a, t);
        expect_lit(d, e);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_type  = 3'b010;
        mem[30'h40] = 32'h44332211;
        mem[30'h41] = 32'h88776655;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        load(32'h100, 3'b010, 32'h44332211, 1'b0);
        load(32'h103, 3'b000, 32'h00000044, 1'b0);
        load(32'h107, 3'b000, 32'hFFFFFF88, 1'b0);
        load(32'h107, 3'b100, 32'h00000088, 1'b0);
        load(32'h103, 3'b001, 32'h00005544, 1'b0);
        load(32'h102, 3'b010, 32'h66554433, 1'b0);

        mem[30'h3FFFFFFF] = 32'hAABBCCDD;
        mem[30'h0]        = 32'h00000011;
        load(32'hFFFFFFFD, 3'b010, 32'h11AABBCC, 1'b0);

        // Reset while the second word of a split halfword is being captured.
        issue(32'h103, 3'b001);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        load(32'h106, 3'b101, 32'h00008877, 1'b0);

        load(32'h100, 3'b011, 32'h00000000, 1'b1);
        issue(32'h100, 3'b011);
        issue(32'h100, 3'b001);
        expect_lit(32'h00002211, 1'b0);

        for (int i = 0; i < 16; i++) mem[30'(32'h40 + i)] = $urandom;
        mem[30'h3FFFFFFF] = $urandom;
        mem[30'h0]        = $urandom;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) issue(32'hFFFFFFFC + $urandom_range(0, 3), 3'($urandom_range(0, 7)));
            else                           issue(32'h100 + $urandom_range(0, 63), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) begin
                while (cyc <= acc + lat) @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        while (cyc <= acc + lat) @(negedge clk);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
